mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Shares the single uncached memory port (cbus) between the core's instruction bus (ibus) and
// data bus (dbus). Sits between core and memory interconnect; one transaction in flight at a time.
// dbus has priority (older instruction), with a starvation limit guaranteeing ibus progress.
// Requests are latched at grant, so requesters may drop valid after the addr_ok handshake.
// PARAMETERS
// STARVE_LIMIT  4  consecutive dbus grants with ireq.valid pending before ibus is forced next (>=1)
// PORTS
// clk    in   1                clock; all state updates on posedge
// reset  in   1                synchronous, active-high reset
// ireq   in   ibus_req_t       fetch request {valid, addr}
// iresp  out  ibus_resp_t      {addr_ok, data_ok, data}
// dreq   in   dbus_req_t       data request {valid, addr, size, strobe, data}
// dresp  out  dbus_resp_t      {addr_ok, data_ok, data}
// creq   out  cbus_req_t       {valid, is_write, size, addr, strobe, data, len, burst}
// cresp  in   cbus_resp_t      {ready, last, data}
// BEHAVIOUR
// - Clock is clk; reset is synchronous, active-high, sampled on posedge clk.
// - Reset: state=IDLE, starve_cnt=0, latched request cleared; creq.valid=0, all addr_ok/data_ok=0,
//   data outputs 0. Reset mid-transaction abandons it: creq.valid low from the cycle after reset
//   is sampled; no data_ok ever issued for the abandoned request.
// - States: IDLE, IFETCH, DACCESS (arb_state_t).
// - IDLE grant rule (combinational in the same cycle):
//   dreq.valid && !(ireq.valid && starve_cnt==STARVE_LIMIT) -> dresp.addr_ok=1, latch dreq, next DACCESS;
//   else ireq.valid -> iresp.addr_ok=1, latch ireq, next IFETCH; else stay IDLE.
// - addr_ok: asserted only in IDLE, for exactly the grant cycle, only to the granted requester.
// - starve_cnt: on dbus grant with ireq.valid=1 -> +1 (saturating at STARVE_LIMIT);
//   on ibus grant, or dbus grant with ireq.valid=0 -> 0.
// - IFETCH/DACCESS: creq.valid=1, driven solely from latched registers (stable until done).
//   IFETCH: is_write=0, size=MSIZE4, strobe=0, data=0. DACCESS: is_write=|strobe, size/addr/
//   strobe/data from latched dreq. Both: len=MLEN1, burst=AXI_BURST_FIXED.
// - Completion: cresp.ready && cresp.last in busy state -> owner's data_ok=1 and data=cresp.data
//   for that cycle only; next state IDLE. cresp.ready without last is ignored (single beat only).
// - Non-owner data_ok always 0; data outputs 0 when data_ok=0.
// - No new grant in the completion cycle: one IDLE cycle between transactions.
//   Minimum latency addr_ok -> data_ok = 1 cycle (ready in first busy cycle); unbounded stall allowed.
// - Requests arriving while busy wait (addr_ok=0); requester must hold valid until addr_ok.
// - Addresses/data pass unmodified (64-bit addr, 64-bit data); no alignment checks here.
// STRUCTURE
// - arb_state_t enum {IDLE, IFETCH, DACCESS} goes into common package; bus structs, MSIZE*/MLEN*
//   and AXI_BURST_* constants already live there.
// - Single flat module: FSM + latched request register + starve counter. No sub-module.
// TESTING
// - Lone fetch: ireq{valid,addr=0x8000_0000}, cresp.ready&last 2 cycles later, data=0x13 ->
//   iresp.addr_ok in grant cycle, creq{valid,is_write=0,size=MSIZE4,addr=0x8000_0000}, one-cycle
//   iresp.data_ok with data=0x13; dresp stays 0.
// - Conflict: ireq and dreq{addr=0x8000_1000,strobe=0xFF,data=0xDEAD} same cycle -> dbus granted,
//   creq.is_write=1, strobe=0xFF; after completion + 1 idle cycle ibus granted.
// - Starvation: dreq held valid back-to-back with ireq pending, STARVE_LIMIT=4 -> exactly 4 dbus
//   transactions, then ibus granted, then dbus again; starve_cnt back to 0.
// - Valid drop: requester deasserts dreq.valid after addr_ok and changes addr -> creq fields stay at
//   latched values until ready&last; ready without last for 3 cycles -> no data_ok.
// - Reset mid-op: reset during DACCESS with ready low -> next cycle creq.valid=0, IDLE, no data_ok;
//   pending ireq granted on first post-reset cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the core-side memory port: ibus/dbus/cbus structs,
// transfer size/length/burst encodings and the arbiter state enum.
package mem_bus_arbiter_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Encoded as beats-1, AXI style.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    msize_t     size;
    addr_t      addr;
    strobe_t    strobe;
    word_t      data;
    mlen_t      len;
    axi_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Single-beat instruction fetch: always a full 32-bit read.
  function automatic cbus_req_t make_ifetch_req(input addr_t addr);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = 1'b0;
    c.size     = MSIZE4;
    c.addr     = addr;
    c.strobe   = '0;
    c.data     = '0;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

  // Single-beat data access: any byte strobe set makes it a write.
  function automatic cbus_req_t make_daccess_req(input dbus_req_t d);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = |d.strobe;
    c.size     = d.size;
    c.addr     = d.addr;
    c.strobe   = d.strobe;
    c.data     = d.data;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single uncached cbus port between ibus and dbus, one transaction
// in flight; dbus wins ties unless ibus has been starved STARVE_LIMIT times.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4   // must be >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  cbus_req_t        req_q;
  logic [CNT_W-1:0] starve_cnt;

  logic ibus_starved;
  logic grant_d;
  logic grant_i;
  logic done;

  // Valid/ready contract: a requester raises valid and holds its request
  // until it sees addr_ok in the same cycle; after that the arbiter owns a
  // latched copy and valid may drop. data_ok is a one-cycle pulse to the
  // owner carrying the read data; there is no backpressure on data_ok.
  always_comb begin
    ibus_starved = ireq.valid && (starve_cnt == CNT_MAX);
    grant_d      = !reset && (state == IDLE) && dreq.valid && !ibus_starved;
    grant_i      = !reset && (state == IDLE) && ireq.valid && !grant_d;
    done         = !reset && (state != IDLE) && cresp.ready && cresp.last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state <= DACCESS;
            req_q <= make_daccess_req(dreq);
            if (!ireq.valid) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (grant_i) begin
            state      <= IFETCH;
            req_q      <= make_ifetch_req(ireq.addr);
            starve_cnt <= '0;
          end
        end
        IFETCH, DACCESS: begin
          // A ready beat without last is not a completion for single-beat traffic.
          if (cresp.ready && cresp.last) begin
            state <= IDLE;
            req_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= '0;
        end
      endcase
    end
  end

  // The cbus request is the latched copy, so it cannot follow the requester.
  assign creq = req_q;

  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.addr_ok = grant_i;
    dresp.addr_ok = grant_d;
    if (done && (state == IFETCH)) begin
      iresp.data_ok = 1'b1;
      iresp.data    = cresp.data;
    end
    if (done && (state == DACCESS)) begin
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected grants and responses are queued
// at stimulus time and checked by an independent negedge monitor.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic      is_d;
    cbus_req_t creq;
  } grant_t;

  localparam int GW = $bits(grant_t);
  localparam int RW = 65;

  logic [GW-1:0] grant_q[$];
  logic [RW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          exp_busy = 1'b0;
  cbus_req_t     cur_exp = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cbus_req_t cexp(input logic w, input msize_t sz, input logic [63:0] a,
                                     input logic [7:0] s, input logic [63:0] d);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = w;
    c.size     = sz;
    c.addr     = a;
    c.strobe   = s;
    c.data     = d;
    c.len      = MLEN1;
    c.burst    = AXI_BURST_FIXED;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input logic is_d, input cbus_req_t c);
    grant_t g;
    g.is_d = is_d;
    g.creq = c;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input logic is_d, input logic [63:0] d);
    exp_q.push_back({is_d, d});
  endtask

  task automatic mem_reply(input logic [63:0] d);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = d;
  endtask

  task automatic mem_idle();
    cresp = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    grant_t        g;
    logic [RW-1:0] r;
    logic          nxt_busy;
    if (reset) begin
      exp_busy = 1'b0;
    end else begin
      nxt_busy = exp_busy;
      if (exp_busy) check("creq_busy", 256'(creq), 256'(cur_exp));
      else          check("creq_idle_valid", 256'(creq.valid), 256'(0));
      check("addr_ok_exclusive", 256'(iresp.addr_ok & dresp.addr_ok), 256'(0));
      check("data_ok_exclusive", 256'(iresp.data_ok & dresp.data_ok), 256'(0));
      if (!iresp.data_ok) check("iresp_data_zero", 256'(iresp.data), 256'(0));
      if (!dresp.data_ok) check("dresp_data_zero", 256'(dresp.data), 256'(0));
      if (iresp.addr_ok || dresp.addr_ok) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 256'({iresp.addr_ok, dresp.addr_ok}), 256'(0));
        end else begin
          g = grant_t'(grant_q.pop_front());
          check("grant_owner_is_d", 256'(dresp.addr_ok), 256'(g.is_d));
          cur_exp  = g.creq;
          nxt_busy = 1'b1;
        end
      end
      if (iresp.data_ok || dresp.data_ok) begin
        if (exp_q.size() == 0) begin
          check("unexpected_data_ok", 256'({iresp.data_ok, dresp.data_ok}), 256'(0));
        end else begin
          r = exp_q.pop_front();
          check("resp_owner_data",
                256'({dresp.data_ok, (dresp.data_ok ? dresp.data : iresp.data)}), 256'(r));
          nxt_busy = 1'b0;
        end
      end
      exp_busy = nxt_busy;
    end
  end

  // ---------------- stimulus ----------------
  logic own_d [6];

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    own_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state, with a request present that must not be granted.
    tick();
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    tick();
    check("reset_creq", 256'(creq), 256'(0));
    check("reset_iresp", 256'(iresp), 256'(0));
    check("reset_dresp", 256'(dresp), 256'(0));
    ireq  = '0;
    reset = 1'b0;
    tick();

    // Lone fetch: data returns two cycles after the grant.
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    push_grant(1'b0, cexp(1'b0, MSIZE4, 64'h8000_0000, 8'h00, 64'h0));
    tick();
    ireq = '0;
    tick();
    mem_reply(64'h13);
    push_resp(1'b0, 64'h13);
    tick();
    mem_idle();
    tick();

    // Conflict: dbus write first, ibus granted in the following idle cycle.
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h8000_0040;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_1000;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD;
    push_grant(1'b1, cexp(1'b1, MSIZE8, 64'h8000_1000, 8'hFF, 64'hDEAD));
    push_grant(1'b0, cexp(1'b0, MSIZE4, 64'h8000_0040, 8'h00, 64'h0));
    tick();
    dreq.valid = 1'b0;
    mem_reply(64'h0);
    push_resp(1'b1, 64'h0);
    tick();
    mem_idle();
    tick();
    ireq.valid = 1'b0;
    mem_reply(64'h77);
    push_resp(1'b0, 64'h77);
    tick();
    mem_idle();
    tick();

    // Starvation: four dbus grants, then ibus is forced, then dbus again.
    for (int k = 0; k < 6; k++) begin
      ireq.valid  = (k < 5);
      ireq.addr   = 64'h8000_0100;
      dreq.valid  = 1'b1;
      dreq.addr   = 64'h2000 + 64'(k * 8);
      dreq.size   = MSIZE8;
      dreq.strobe = 8'h00;
      dreq.data   = 64'h0;
      if (own_d[k]) push_grant(1'b1, cexp(1'b0, MSIZE8, 64'h2000 + 64'(k * 8), 8'h00, 64'h0));
      else          push_grant(1'b0, cexp(1'b0, MSIZE4, 64'h8000_0100, 8'h00, 64'h0));
      tick();
      if (!own_d[k]) ireq.valid = 1'b0;
      if (k == 5)    dreq.valid = 1'b0;
      mem_reply(64'h1000 + 64'(k));
      push_resp(own_d[k], 64'h1000 + 64'(k));
      tick();
      mem_idle();
    end
    tick();

    // Valid drop: requester changes its fields after addr_ok; ready without last is ignored.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h3000;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h0F;
    dreq.data   = 64'hCAFE;
    push_grant(1'b1, cexp(1'b1, MSIZE4, 64'h3000, 8'h0F, 64'hCAFE));
    tick();
    dreq.valid  = 1'b0;
    dreq.addr   = 64'hFFFF_0000;
    dreq.data   = 64'h1234;
    dreq.strobe = 8'h00;
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = 64'hBAD;
    tick();
    tick();
    tick();
    mem_reply(64'hAB);
    push_resp(1'b1, 64'hAB);
    tick();
    mem_idle();
    tick();

    // Reset mid-access: transaction abandoned, waiting ibus granted right after reset.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h4000;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h5A;
    push_grant(1'b1, cexp(1'b1, MSIZE8, 64'h4000, 8'hFF, 64'h5A));
    tick();
    dreq.valid = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0200;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_creq_valid", 256'(creq.valid), 256'(0));
    push_grant(1'b0, cexp(1'b0, MSIZE4, 64'h8000_0200, 8'h00, 64'h0));
    tick();
    ireq.valid = 1'b0;
    mem_reply(64'h99);
    push_resp(1'b0, 64'h99);
    tick();
    mem_idle();
    repeat (3) tick();

    // ---------------- final report ----------------
    check("grant_q_drained", 256'(grant_q.size()), 256'(0));
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
